// File: rtl/secuenciador_rampa_pkg.sv
// Shared definitions for the motor ramp sequencer: state encoding and
// default dwell times. No ports; imported by secuenciador_rampa.
package secuenciador_rampa_pkg;

  localparam int ST_W = 3;
  typedef logic [ST_W-1:0] estado_t;

  localparam logic [2:0] ST_OFF    = 3'd0;
  localparam logic [2:0] ST_UP30   = 3'd1;
  localparam logic [2:0] ST_UP50   = 3'd2;
  localparam logic [2:0] ST_RUN100 = 3'd3;
  localparam logic [2:0] ST_DN50   = 3'd4;
  localparam logic [2:0] ST_DN30   = 3'd5;
  localparam logic [2:0] ST_FAULT  = 3'd6;

  localparam int DWELL_W_DEF = 16;
  localparam int T30_DEF     = 1000;
  localparam int T50_DEF     = 1000;
  localparam int TDN_DEF     = 500;

  // States that leave on their own after a fixed number of cycles.
  function automatic logic es_dwell(input estado_t s);
    return (s == ST_UP30) || (s == ST_UP50) || (s == ST_DN50) || (s == ST_DN30);
  endfunction

endpackage

// File: rtl/secuenciador_rampa_contador_dwell.sv
// Dwell counter: counts cycles spent in the current stage and flags the
// terminal count. Saturates at limit, never wraps.
// Ports: clk, reset (sync, active-low), clear (restart from 0),
//        enable (count this cycle), limit (terminal value), tc (cnt == limit).
module contador_dwell #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] limit,
  output logic               tc
);

  logic [DWELL_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != limit)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/secuenciador_rampa.sv
// Motor ramp sequencer: steps a motor through 30% -> 50% -> 100% on start
// (or 30% -> 100% in fast mode) and back down through 50% -> 30% on stop.
// A fault latches until acknowledged.
// Ports: clk, reset (sync, active-low), start, stop, rapido (fast mode,
//        captured on accepted start), fault (level), clear_fault,
//        out_30/out_50/out_100 (one-hot stage select), busy, fault_o.
//
// state  | meaning
// OFF    | motor off, waiting for start
// UP30   | ramp-up, 30% stage, T30 cycles
// UP50   | ramp-up, 50% stage, T50 cycles
// RUN100 | full speed until stop or fault
// DN50   | ramp-down, 50% stage, TDN cycles
// DN30   | ramp-down, 30% stage, TDN cycles
// FAULT  | latched fault, all stages off
module secuenciador_rampa
  import secuenciador_rampa_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int T30     = T30_DEF,
  parameter int T50     = T50_DEF,
  parameter int TDN     = TDN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic rapido,
  input  logic fault,
  input  logic clear_fault,
  output logic out_30,
  output logic out_50,
  output logic out_100,
  output logic busy,
  output logic fault_o
);

  if (T30 < 1 || T30 > (2**DWELL_W) - 1) begin : g_chk_t30
    $error("T30 out of range for DWELL_W");
  end
  if (T50 < 1 || T50 > (2**DWELL_W) - 1) begin : g_chk_t50
    $error("T50 out of range for DWELL_W");
  end
  if (TDN < 1 || TDN > (2**DWELL_W) - 1) begin : g_chk_tdn
    $error("TDN out of range for DWELL_W");
  end

  estado_t            state;
  estado_t            state_next;
  logic               mode;
  logic               accept;
  logic               tc;
  logic               cnt_clear;
  logic               cnt_en;
  logic [DWELL_W-1:0] limit;

  // Terminal value is T-1: the counter starts at 0 on entry, so the state
  // is held for exactly T cycles.
  always_comb begin
    limit = '0;
    case (state)
      ST_UP30:          limit = DWELL_W'(T30 - 1);
      ST_UP50:          limit = DWELL_W'(T50 - 1);
      ST_DN50, ST_DN30: limit = DWELL_W'(TDN - 1);
      default:          limit = '0;
    endcase
  end

  assign accept = (state == ST_OFF) && start && !stop && !fault;

  always_comb begin
    state_next = state;
    if (fault) begin
      state_next = ST_FAULT;
    end else begin
      case (state)
        ST_OFF:    if (start && !stop) state_next = ST_UP30;
        ST_UP30: begin
          if (stop)    state_next = ST_OFF;
          else if (tc) state_next = mode ? ST_RUN100 : ST_UP50;
        end
        ST_UP50: begin
          if (stop)    state_next = ST_DN30;
          else if (tc) state_next = ST_RUN100;
        end
        ST_RUN100: if (stop) state_next = ST_DN50;
        ST_DN50:   if (tc) state_next = ST_DN30;
        ST_DN30:   if (tc) state_next = ST_OFF;
        ST_FAULT:  if (clear_fault) state_next = ST_OFF;
        default:   state_next = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_OFF;
      mode  <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) mode <= rapido;
    end
  end

  // Any state change restarts the dwell count for the state being entered.
  assign cnt_clear = (state_next != state);
  assign cnt_en    = es_dwell(state);

  contador_dwell #(
    .DWELL_W(DWELL_W)
  ) u_contador_dwell (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .limit  (limit),
    .tc     (tc)
  );

  assign out_30  = (state == ST_UP30) || (state == ST_DN30);
  assign out_50  = (state == ST_UP50) || (state == ST_DN50);
  assign out_100 = (state == ST_RUN100);
  assign busy    = es_dwell(state) || (state == ST_RUN100);
  assign fault_o = (state == ST_FAULT);

endmodule

// File: tb/tb_secuenciador_rampa.sv
module tb_secuenciador_rampa;

  localparam int T30 = 4;
  localparam int T50 = 3;
  localparam int TDN = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic rapido = 1'b0;
  logic fault = 1'b0;
  logic clear_fault = 1'b0;
  logic out_30, out_50, out_100, busy, fault_o;

  always #5 clk = ~clk;

  secuenciador_rampa #(
    .DWELL_W(8),
    .T30    (T30),
    .T50    (T50),
    .TDN    (TDN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .rapido      (rapido),
    .fault       (fault),
    .clear_fault (clear_fault),
    .out_30      (out_30),
    .out_50      (out_50),
    .out_100     (out_100),
    .busy        (busy),
    .fault_o     (fault_o)
  );

  // Reference model: current phase plus cycles still to spend in it.
  typedef enum int {P_OFF, P_UP30, P_UP50, P_RUN, P_DN50, P_DN30, P_FAULT} phase_e;
  typedef struct {
    logic [4:0] v;
    phase_e     ph;
  } exp_t;

  phase_e ph = P_OFF;
  int     left = 0;
  bit     mode = 1'b0;
  exp_t   q[$];
  int     checks = 0;
  int     errors = 0;

  function automatic int dwell_of(input phase_e p);
    case (p)
      P_UP30:         return T30;
      P_UP50:         return T50;
      P_DN50, P_DN30: return TDN;
      default:        return 0;
    endcase
  endfunction

  function automatic logic [4:0] outs_of(input phase_e p);
    // {out_30, out_50, out_100, busy, fault_o}
    case (p)
      P_UP30, P_DN30: return 5'b10010;
      P_UP50, P_DN50: return 5'b01010;
      P_RUN:          return 5'b00110;
      P_FAULT:        return 5'b00001;
      default:        return 5'b00000;
    endcase
  endfunction

  function void go(input phase_e p);
    ph   = p;
    left = dwell_of(p);
  endfunction

  // One spent cycle in a timed phase; returns 1 when this was the last one.
  function bit expired();
    if (left <= 1) return 1'b1;
    left = left - 1;
    return 1'b0;
  endfunction

  function void model(input logic rs, st, sp, rap, flt, clr);
    if (!rs) begin
      go(P_OFF);
      mode = 1'b0;
    end else if (flt) begin
      go(P_FAULT);
    end else begin
      case (ph)
        P_OFF:   if (st && !sp) begin go(P_UP30); mode = rap; end
        P_UP30:  if (sp) go(P_OFF); else if (expired()) go(mode ? P_RUN : P_UP50);
        P_UP50:  if (sp) go(P_DN30); else if (expired()) go(P_RUN);
        P_RUN:   if (sp) go(P_DN50);
        P_DN50:  if (expired()) go(P_DN30);
        P_DN30:  if (expired()) go(P_OFF);
        P_FAULT: if (clr) go(P_OFF);
        default: go(P_OFF);
      endcase
    end
  endfunction

  task automatic step(input logic rs, st, sp, rap, flt, clr);
    exp_t e;
    @(negedge clk);
    reset = rs; start = st; stop = sp; rapido = rap; fault = flt; clear_fault = clr;
    model(rs, st, sp, rap, flt, clr);
    e.v  = outs_of(ph);
    e.ph = ph;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every clock the DUT presents a new output vector.
  initial begin
    exp_t       e;
    logic [4:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {out_30, out_50, out_100, busy, fault_o};
        checks++;
        if (got !== e.v) begin
          errors++;
          $display("FAIL outputs phase=%s got=%b expected=%b t=%0t", e.ph.name(), got, e.v, $time);
        end
      end
    end
  end

  initial begin
    // reset
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    // normal ramp-up, then stop from RUN100
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    // fast mode
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(7);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);
    // fault in second cycle of UP50, clear while fault held, then clear
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(5);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // start+stop in OFF; stop in UP30; start during DN50
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    // reset during RUN100, then restart
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(10);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(2);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) >= 1) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 25) ? 1'b1 : 1'b0,
           ($urandom_range(99) < 8)  ? 1'b1 : 1'b0,
           1'($urandom_range(1)),
           ($urandom_range(99) < 3)  ? 1'b1 : 1'b0,
           ($urandom_range(99) < 30) ? 1'b1 : 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
